alu_multicycle: RTL and testbench

//  Execute-stage ALU successor: parametrised width, full RV integer op set (shifts, compares),

---
 rtl/alu_multicycle.sv | 195 +++++++++++++++++++
 tb/tb_alu_multicycle.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/alu_multicycle.sv
// Execute-stage ALU with RV integer ops plus iterative MUL/DIV/REM behind valid/ready handshakes.
// Optional ALU_WORD_OP_EN adds the word_op port for RV64 *W operations (WIDTH must be 64).
module alu_multicycle #(
  parameter int unsigned WIDTH   = 64,
  parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
`ifdef ALU_WORD_OP_EN
  input  logic             word_op,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             busy
);

  localparam int unsigned CNT_W = SHAMT_W + 1;

  typedef enum logic [2:0] {S_IDLE, S_ONE, S_MUL, S_DIV, S_DONE} state_e;
  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL, OP_SRA,
    OP_SLT, OP_SLTU, OP_MUL, OP_DIV, OP_DIVU, OP_REM, OP_REMU, OP_RSVD
  } op_e;

  state_e             state_q;
  op_e                op_q;
  logic [CNT_W-1:0]   cnt_q, iter_lim;
  logic [WIDTH-1:0]   s1_q, s2_q, acc_q, x_q, y_q, result_q;
  logic               qneg_q, rneg_q, dz_q;
`ifdef ALU_WORD_OP_EN
  logic               word_q, word_in;
`endif

  logic [WIDTH-1:0]   a_in, b_in, mag_a, mag_b, x_init;
  logic               is_sdiv, a_neg, b_neg;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   one_raw, one_d, quot, rem, fin_raw, fin_d;
  logic [WIDTH:0]     rem_sh, diff;

  // Operand preparation at accept time.
  always_comb begin
    a_in = src1;
    b_in = src2;
`ifdef ALU_WORD_OP_EN
    word_in = word_op && !(op_e'(op) inside {OP_AND, OP_OR, OP_XOR, OP_SLT, OP_SLTU});
    if (word_in) begin
      if (op_e'(op) inside {OP_SRL, OP_DIVU, OP_REMU}) begin
        a_in = {{(WIDTH-32){1'b0}}, src1[31:0]};
        b_in = {{(WIDTH-32){1'b0}}, src2[31:0]};
      end else begin
        a_in = {{(WIDTH-32){src1[31]}}, src1[31:0]};
        b_in = {{(WIDTH-32){src2[31]}}, src2[31:0]};
      end
    end
`endif
    is_sdiv = op_e'(op) inside {OP_DIV, OP_REM};
    a_neg   = is_sdiv && a_in[WIDTH-1];
    b_neg   = is_sdiv && b_in[WIDTH-1];
    mag_a   = a_neg ? -a_in : a_in;
    mag_b   = b_neg ? -b_in : b_in;
    x_init  = mag_a;
`ifdef ALU_WORD_OP_EN
    // Word divides park the 32-bit dividend in the top half so 32 shifts consume it.
    if (word_in) x_init = mag_a << 32;
`endif
  end

  // Single-cycle results, restoring-divide step and final result selection.
  always_comb begin
    shamt    = s2_q[SHAMT_W-1:0];
    iter_lim = CNT_W'(WIDTH);
`ifdef ALU_WORD_OP_EN
    if (word_q) begin
      shamt    = {{(SHAMT_W-5){1'b0}}, s2_q[4:0]};
      iter_lim = CNT_W'(32);
    end
`endif
    case (op_q)
      OP_ADD:  one_raw = s1_q + s2_q;
      OP_SUB:  one_raw = s1_q - s2_q;
      OP_AND:  one_raw = s1_q & s2_q;
      OP_OR:   one_raw = s1_q | s2_q;
      OP_XOR:  one_raw = s1_q ^ s2_q;
      OP_SLL:  one_raw = s1_q << shamt;
      OP_SRL:  one_raw = s1_q >> shamt;
      OP_SRA:  one_raw = WIDTH'($signed(s1_q) >>> shamt);
      OP_SLT:  one_raw = {{(WIDTH-1){1'b0}}, $signed(s1_q) < $signed(s2_q)};
      OP_SLTU: one_raw = {{(WIDTH-1){1'b0}}, s1_q < s2_q};
      default: one_raw = '0;
    endcase

    rem_sh = {acc_q, x_q[WIDTH-1]};
    diff   = rem_sh - {1'b0, y_q};

    quot = qneg_q ? -x_q : x_q;
    rem  = rneg_q ? -acc_q : acc_q;
    if (dz_q) begin
      quot = '1;
      rem  = s1_q;
    end
    if (op_q == OP_MUL)                      fin_raw = acc_q;
    else if (op_q inside {OP_DIV, OP_DIVU})  fin_raw = quot;
    else                                     fin_raw = rem;

    one_d = one_raw;
    fin_d = fin_raw;
`ifdef ALU_WORD_OP_EN
    if (word_q) begin
      one_d = {{(WIDTH-32){one_raw[31]}}, one_raw[31:0]};
      fin_d = {{(WIDTH-32){fin_raw[31]}}, fin_raw[31:0]};
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      result_q <= '0;
    end else if (flush) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (in_valid) begin
          op_q   <= op_e'(op);
          s1_q   <= a_in;
          s2_q   <= b_in;
          cnt_q  <= '0;
          acc_q  <= '0;
          qneg_q <= a_neg ^ b_neg;
          rneg_q <= a_neg;
          dz_q   <= (b_in == '0);
`ifdef ALU_WORD_OP_EN
          word_q <= word_in;
`endif
          case (op_e'(op))
            OP_MUL: begin
              state_q <= S_MUL;
              x_q     <= a_in;
              y_q     <= b_in;
            end
            OP_DIV, OP_DIVU, OP_REM, OP_REMU: begin
              state_q <= S_DIV;
              x_q     <= x_init;
              y_q     <= mag_b;
            end
            default: state_q <= S_ONE;
          endcase
        end
        S_ONE: begin
          result_q <= one_d;
          state_q  <= S_DONE;
        end
        S_MUL: if (cnt_q == iter_lim) begin
          result_q <= fin_d;
          state_q  <= S_DONE;
        end else begin
          if (y_q[0]) acc_q <= acc_q + x_q;
          x_q   <= x_q << 1;
          y_q   <= y_q >> 1;
          cnt_q <= cnt_q + 1'b1;
        end
        S_DIV: if (cnt_q == iter_lim) begin
          result_q <= fin_d;
          state_q  <= S_DONE;
        end else begin
          if (!diff[WIDTH]) begin
            acc_q <= diff[WIDTH-1:0];
            x_q   <= {x_q[WIDTH-2:0], 1'b1};
          end else begin
            acc_q <= rem_sh[WIDTH-1:0];
            x_q   <= {x_q[WIDTH-2:0], 1'b0};
          end
          cnt_q <= cnt_q + 1'b1;
        end
        S_DONE: if (out_ready) state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q == S_MUL) || (state_q == S_DIV);
  assign result    = result_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed self-checking bench for alu_multicycle at WIDTH=64 (default build, no word ops).
module tb_alu_multicycle;
  localparam int unsigned W = 64;

  logic         clk = 1'b0;
  logic         reset, flush, in_valid, in_ready, out_valid, out_ready, busy;
  logic [3:0]   op;
  logic [W-1:0] src1, src2, result;
  int           total = 0;
  int           bad = 0;
  int           n;
  logic         sawv;

  always #5 clk = ~clk;

  alu_multicycle #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .src1(src1), .src2(src2), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .busy(busy)
  );

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one op for a single cycle, then scramble the inputs to prove they were latched.
  task automatic issue(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    in_valid = 1'b1; op = o; src1 = a; src2 = b;
    step();
    in_valid = 1'b0; op = 4'd1; src1 = '1; src2 = 64'h5;
  endtask

  task automatic wait_out(input int lim, output int cyc);
    cyc = 0;
    while (!out_valid && cyc < lim) begin
      step();
      cyc++;
    end
  endtask

  task automatic take();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic run(input string tag, input logic [3:0] o, input logic [W-1:0] a,
                     input logic [W-1:0] b, input logic [W-1:0] exp, input int lat);
    int c;
    issue(o, a, b);
    chk({tag, "_inrdy_busy"}, in_ready, 1'b0);
    wait_out(lat + 10, c);
    chk({tag, "_lat"}, c, lat);
    chk({tag, "_res"}, result, exp);
    take();
    chk({tag, "_inrdy_back"}, in_ready, 1'b1);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op = '0; src1 = '0; src2 = '0;
    step(); step();
    reset = 1'b0;
    chk("rst_inrdy", in_ready, 1'b1);
    chk("rst_ovalid", out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_result", result, '0);

    run("add_wrap", 4'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1);
    run("sub", 4'd1, 64'd5, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 1);
    run("and", 4'd2, 64'hF0F0, 64'hFF00, 64'hF000, 1);
    run("or", 4'd3, 64'hF0F0, 64'hFF00, 64'hFFF0, 1);
    run("xor", 4'd4, 64'hF0F0, 64'hFF00, 64'h0FF0, 1);
    run("sll", 4'd5, 64'd1, 64'h41, 64'd2, 1);
    run("srl", 4'd6, 64'h8000_0000_0000_0000, 64'h3F, 64'd1, 1);
    run("sra", 4'd7, 64'h8000_0000_0000_0000, 64'h43, 64'hF000_0000_0000_0000, 1);
    run("slt", 4'd8, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd1, 1);
    run("sltu", 4'd9, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1);
    run("rsvd", 4'd15, 64'd3, 64'd4, 64'd0, 1);

    issue(4'd10, 64'h1_0000_0001, 64'd3);
    n = 0;
    while (!out_valid && n < 100) begin
      chk("mul_busy", busy, 1'b1);
      chk("mul_inrdy", in_ready, 1'b0);
      step();
      n++;
    end
    chk("mul_lat", n, 65);
    chk("mul_res", result, 64'h3_0000_0003);
    chk("mul_done_busy", busy, 1'b0);
    take();
    run("mul_neg", 4'd10, 64'hFFFF_FFFF_FFFF_FFFF, 64'd5, 64'hFFFF_FFFF_FFFF_FFFB, 65);

    run("div_neg", 4'd11, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65);
    run("rem_neg", 4'd13, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65);
    run("div_negdvs", 4'd11, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFD, 65);
    run("rem_negdvs", 4'd13, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 65);
    run("divu", 4'd12, 64'd100, 64'd7, 64'd14, 65);
    run("remu", 4'd14, 64'd100, 64'd7, 64'd2, 65);
    run("divu_dz", 4'd12, 64'd7, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 65);
    run("remu_dz", 4'd14, 64'd7, 64'd0, 64'd7, 65);
    run("div_dz", 4'd11, 64'hFFFF_FFFF_FFFF_FFF9, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 65);
    run("rem_dz", 4'd13, 64'hFFFF_FFFF_FFFF_FFF9, 64'd0, 64'hFFFF_FFFF_FFFF_FFF9, 65);
    run("rem_ovf", 4'd13, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 65);
    run("div_ovf", 4'd11, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
        64'h8000_0000_0000_0000, 65);

    // Back-pressure in DONE while a new op is offered.
    issue(4'd0, 64'd10, 64'd20);
    wait_out(10, n);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; op = 4'd1; src1 = 64'd99; src2 = 64'd1;
      chk("hold_ovalid", out_valid, 1'b1);
      chk("hold_res", result, 64'd30);
      chk("hold_inrdy", in_ready, 1'b0);
      step();
    end
    in_valid = 1'b0;
    take();
    chk("hold_inrdy_back", in_ready, 1'b1);
    chk("hold_no_accept", out_valid, 1'b0);
    step();
    chk("hold_still_idle", in_ready, 1'b1);

    // Flush during a divide.
    issue(4'd12, 64'd100, 64'd7);
    for (int i = 0; i < 19; i++) step();
    chk("flush_busy_before", busy, 1'b1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_inrdy", in_ready, 1'b1);
    chk("flush_busy", busy, 1'b0);
    sawv = 1'b0;
    for (int i = 0; i < 70; i++) begin
      sawv = sawv | out_valid;
      step();
    end
    chk("flush_no_result", sawv, 1'b0);
    run("add_after_flush", 4'd0, 64'd2, 64'd3, 64'd5, 1);

    // Flush wins over a same-cycle accept.
    in_valid = 1'b1; op = 4'd0; src1 = 64'd1; src2 = 64'd1; flush = 1'b1;
    step();
    in_valid = 1'b0; flush = 1'b0;
    chk("flush_acc_inrdy", in_ready, 1'b1);
    step(); step();
    chk("flush_acc_ovalid", out_valid, 1'b0);

    // Reset in the middle of a multiply clears the held result.
    issue(4'd10, 64'd3, 64'd3);
    for (int i = 0; i < 10; i++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("midrst_result", result, '0);
    chk("midrst_inrdy", in_ready, 1'b1);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_ovalid", out_valid, 1'b0);
    run("mul_after_rst", 4'd10, 64'd6, 64'd7, 64'd42, 65);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
